// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, instruction
// field positions, FSM state encoding and the datapath width.
package ctrl_pkg;

  localparam int DATA_W = 8;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int RD_BIT  = 4;
  localparam int RS_BIT  = 3;
  localparam int IMM_MSB = 2;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MUL,
    S_WB,
    S_HALTED
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier. The first partial product is folded into
// the start cycle so the full product is ready after exactly MUL_STEPS cycles.
module mul_shift_add
  import ctrl_pkg::*;
#(
  parameter int MUL_STEPS = DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(MUL_STEPS + 1);

  logic [DATA_W-1:0] mcand;
  logic [CNT_W-1:0]  cnt;

  // Upper half accumulates the multiplicand, lower half shifts out multiplier bits.
  function automatic logic [2*DATA_W-1:0] step(input logic [2*DATA_W-1:0] acc,
                                               input logic [DATA_W-1:0]   m);
    logic [DATA_W:0] upper;
    upper = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, m} : '0);
    return {upper, acc[DATA_W-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      product <= '0;
    end else if (start) begin
      product <= step({{DATA_W{1'b0}}, b}, a);
      mcand   <= a;
      cnt     <= CNT_W'(MUL_STEPS - 1);
      busy    <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        product <= step(product, mcand);
        cnt     <= cnt - 1'b1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done = busy && (cnt == '0);

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle sequencer driving a two-entry register file.
// Define SEQ_MUL_EN to enable opcode 110 (MUL) via mul_shift_add.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int MUL_STEPS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              read_register,
  output logic              write_register,
  output logic              register_write,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              illegal_op,
  output logic              halted
);

  if (MUL_STEPS != DATA_W) begin : g_bad_mul_steps
    $error("MUL_STEPS must equal the data width");
  end

  state_t            state, next_state;
  logic [DATA_W-1:0] instr_q;
  logic [2:0]        opcode;
  logic [DATA_W:0]   sum9, diff9;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              illegal;
  logic              accept;

`ifdef SEQ_MUL_EN
  logic                mul_start, mul_busy, mul_done;
  logic [2*DATA_W-1:0] mul_product;

  mul_shift_add #(.MUL_STEPS(MUL_STEPS)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (read_data1),
    .b       (read_data2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  assign opcode         = instr_q[OPC_MSB:OPC_LSB];
  assign read_register  = instr_q[RS_BIT];
  assign write_register = instr_q[RD_BIT];
  assign accept         = (state == S_IDLE) && instr_valid && instr_ready;
  assign sum9           = {1'b0, read_data1} + {1'b0, read_data2};
  assign diff9          = {1'b0, read_data1} - {1'b0, read_data2};

  always_comb begin
    next_state = state;
    illegal    = 1'b0;
    alu_res    = '0;
    alu_carry  = 1'b0;
`ifdef SEQ_MUL_EN
    mul_start  = 1'b0;
`endif
    case (opcode)
      OP_ADD: begin alu_res = sum9[DATA_W-1:0];  alu_carry = sum9[DATA_W];  end
      OP_SUB: begin alu_res = diff9[DATA_W-1:0]; alu_carry = diff9[DATA_W]; end
      OP_AND: alu_res = read_data1 & read_data2;
      OP_OR:  alu_res = read_data1 | read_data2;
      OP_LDI: alu_res = {{(DATA_W-3){1'b0}}, instr_q[IMM_MSB:IMM_LSB]};
      default: ;
    endcase
    case (state)
      S_IDLE:   if (accept) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_NOP:  next_state = S_IDLE;
          OP_HALT: next_state = S_HALTED;
          OP_MUL: begin
`ifdef SEQ_MUL_EN
            next_state = S_MUL;
            mul_start  = 1'b1;
`else
            illegal    = 1'b1;
            next_state = S_IDLE;
`endif
          end
          default: next_state = S_WB;
        endcase
      end
`ifdef SEQ_MUL_EN
      S_MUL:    if (mul_done || !mul_busy) next_state = S_WB;
`endif
      S_WB:     next_state = S_IDLE;
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_IDLE;
    endcase
  end

  // Result and flags are loaded on entry to WB so they only change there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      instr_ready <= 1'b0;
      write_data  <= '0;
      zero_flag   <= 1'b0;
      carry_flag  <= 1'b0;
    end else begin
      state       <= next_state;
      instr_ready <= (next_state == S_IDLE);
      if (accept) instr_q <= instr;
      if (state == S_EXEC && next_state == S_WB) begin
        write_data <= alu_res;
        zero_flag  <= (alu_res == '0);
        carry_flag <= alu_carry;
      end
`ifdef SEQ_MUL_EN
      if (state == S_MUL && next_state == S_WB) begin
        write_data <= mul_product[DATA_W-1:0];
        zero_flag  <= (mul_product[DATA_W-1:0] == '0);
        carry_flag <= |mul_product[2*DATA_W-1:DATA_W];
      end
`endif
    end
  end

  assign register_write = (state == S_WB);
  assign illegal_op     = illegal;
  assign halted         = (state == S_HALTED);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: models the register file, predicts
// each writeback/illegal pulse from the instruction semantics into a scoreboard.
module tb_ctrl_sequencer;

  localparam int MUL_STEPS = 8;

  typedef struct {
    bit         illegal;
    bit         rd;
    logic [7:0] data;
    bit         zero;
    bit         carry;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready, read_register, write_register, register_write;
  logic [7:0] write_data, read_data1, read_data2;
  logic       zero_flag, carry_flag, illegal_op, halted;

  logic [7:0] regs [2];
  logic [7:0] mregs [2];
  bit         mzero, mcarry;
  exp_t       sb[$];
  int         cyc = 0;
  int         n_compared = 0;
  int         n_mismatched = 0;
  int         prev_gap = 0;
  int         last_acc = 0;
  bit         valid_held = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ctrl_sequencer #(.MUL_STEPS(MUL_STEPS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .read_register  (read_register),
    .write_register (write_register),
    .register_write (register_write),
    .write_data     (write_data),
    .read_data1     (read_data1),
    .read_data2     (read_data2),
    .zero_flag      (zero_flag),
    .carry_flag     (carry_flag),
    .illegal_op     (illegal_op),
    .halted         (halted)
  );

  // Two-entry register file sitting downstream of the sequencer.
  assign read_data1 = regs[write_register];
  assign read_data2 = regs[read_register];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs[0] <= 8'd2;
      regs[1] <= 8'd4;
    end else if (register_write) begin
      regs[write_register] <= write_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe or illegal pulse must match the oldest prediction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (register_write === 1'b1 || illegal_op === 1'b1)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_event", 32'({register_write, illegal_op}), 32'(0));
      end else begin
        e = sb.pop_front();
        if (e.illegal) begin
          checkOutput("illegal_pulse", 32'(illegal_op), 32'(1));
          checkOutput("illegal_no_write", 32'(register_write), 32'(0));
        end else begin
          checkOutput("wr_strobe", 32'(register_write), 32'(1));
          checkOutput("wr_reg", 32'(write_register), 32'(e.rd));
          checkOutput("wr_data", 32'(write_data), 32'(e.data));
          checkOutput("zero_flag", 32'(zero_flag), 32'(e.zero));
          checkOutput("carry_flag", 32'(carry_flag), 32'(e.carry));
        end
        checkOutput("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Drives one instruction (called at a negedge) and predicts its outcome.
  task automatic applyStimulus(input logic [7:0] ins, input bit hold);
    int   guard, acc, a, b, res, lat, gap;
    bit   rd, rs, push, ill, c;
    logic [7:0] d;
    exp_t e;
    instr = ins;
    instr_valid = 1'b1;
    guard = 0;
    while (instr_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checkOutput("accept_timeout", 32'(0), 32'(1));
      instr_valid = 1'b0;
      valid_held = 0;
      return;
    end
    acc = cyc;
    if (valid_held && prev_gap > 0) checkOutput("accept_gap", 32'(acc - last_acc), 32'(prev_gap));
    rd = ins[4];
    rs = ins[3];
    a = int'(mregs[rd]);
    b = int'(mregs[rs]);
    push = 1; ill = 0; lat = 3; gap = 4; res = 0; c = 0;
    case (ins[7:5])
      3'd1: begin res = a + b; c = (res > 255); end
      3'd2: begin res = a - b + 256; c = (a < b); end
      3'd3: res = a & b;
      3'd4: res = a | b;
      3'd5: res = int'(ins[2:0]);
      3'd6: begin
`ifdef SEQ_MUL_EN
        res = a * b; c = (res > 255); lat = 3 + MUL_STEPS; gap = 4 + MUL_STEPS;
`else
        ill = 1; lat = 2; gap = 0;
`endif
      end
      default: begin push = 0; gap = 0; end
    endcase
    d = 8'(res % 256);
    if (push) begin
      e.illegal = ill; e.rd = rd; e.data = d; e.zero = (d == 8'd0); e.carry = c; e.due = acc + lat;
      sb.push_back(e);
      if (!ill) begin
        mregs[rd] = d;
        mzero = (d == 8'd0);
        mcarry = c;
      end
    end
    @(negedge clk);
    checkOutput("ready_low_after_accept", 32'(instr_ready), 32'(0));
    if (!hold) instr_valid = 1'b0;
    valid_held = hold;
    last_acc = acc;
    prev_gap = gap;
  endtask

  task automatic waitDrain();
    int guard = 0;
    instr_valid = 1'b0;
    valid_held = 0;
    while ((sb.size() != 0 || instr_ready !== 1'b1) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain", 32'(sb.size()), 32'(0));
    checkOutput("flags_idle", 32'({zero_flag, carry_flag}), 32'({mzero, mcarry}));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    #1;
    checkOutput("reset_outputs", 32'({instr_ready, register_write, write_data, zero_flag, carry_flag,
                                      illegal_op, halted, read_register, write_register}), 32'(0));
    sb.delete();
    mregs[0] = 8'd2;
    mregs[1] = 8'd4;
    mzero = 0;
    mcarry = 0;
    valid_held = 0;
    prev_gap = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("ready_low_after_release", 32'(instr_ready), 32'(0));
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(instr_ready), 32'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] ins;
    doReset();

    // Directed cases from the reset register values r0=2, r1=4.
    applyStimulus(8'b001_0_1_000, 0);   // ADD r0,r1 -> 6
    waitDrain();
    doReset();
    applyStimulus(8'b010_0_1_000, 0);   // SUB r0,r1 -> FE, borrow
    applyStimulus(8'b101_1_0_000, 0);   // LDI r1,#0 -> zero
    waitDrain();

    // Build r0=0x20, r1=0x10 then MUL.
    applyStimulus(8'b101_0_0_100, 1);
    applyStimulus(8'b001_0_0_000, 1);
    applyStimulus(8'b001_0_0_000, 1);
    applyStimulus(8'b001_0_0_000, 1);
    applyStimulus(8'b101_1_0_100, 1);
    applyStimulus(8'b001_1_1_000, 1);
    applyStimulus(8'b001_1_1_000, 1);
    applyStimulus(8'b110_0_1_000, 0);
    waitDrain();
    checkOutput("mul_r0", 32'(regs[0]), 32'(mregs[0]));

    // Randomised instruction stream with optional back-to-back valid.
    for (int i = 0; i < 60; i++) begin
      ins = 8'($urandom_range(0, 255));
      if (ins[7:5] == 3'b111) ins[7:5] = 3'b011;
      applyStimulus(ins, 1'($urandom_range(0, 1)));
      if (!valid_held) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitDrain();
    checkOutput("regfile_r0", 32'(regs[0]), 32'(mregs[0]));
    checkOutput("regfile_r1", 32'(regs[1]), 32'(mregs[1]));

    // HALT is sticky and blocks further instructions.
    applyStimulus(8'b111_0_0_000, 0);
    repeat (3) @(negedge clk);
    checkOutput("halted_set", 32'(halted), 32'(1));
    checkOutput("halted_ready", 32'(instr_ready), 32'(0));
    instr = 8'b001_0_1_000;
    instr_valid = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("halted_sticky", 32'({halted, instr_ready}), 32'(2));
    instr_valid = 1'b0;
    doReset();

    // Reset in the middle of a multiply: no write, then normal operation.
    applyStimulus(8'b110_0_1_000, 0);
    repeat (5) @(negedge clk);
    doReset();
    checkOutput("abort_regs", 32'({regs[0], regs[1]}), 32'({8'd2, 8'd4}));
    applyStimulus(8'b001_0_1_000, 0);
    waitDrain();

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
